rot_arbiter: RTL
================

# rot_arbiter

Shared-access controller for the 16-bit rotate datapath in the UART ALU. Two requesters (A: UART command decoder, B: ALU microsequencer) submit rotate operations over valid/ready. A round-robin arbiter grants one request at a time, the block computes the rotation and returns it on a single buffered response channel tagged with the requester ID.

## Interface
- N, 16, data width; power of two, ≥ 4
- AW, log2(N) = 4, rotate-amount width; derived, not overridden
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  requester A has a command
- a_ready  out  1  A command accepted this cycle
- a_data  in  N  A operand
- a_amt  in  AW  A rotate amount
- a_dir  in  1  A direction: 1 left, 0 right
- b_valid, b_ready, b_data, b_amt, b_dir  same as A, for requester B
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  N  rotated word
- rsp_id  out  1  0 = A, 1 = B
- rsp_zero  out  1  rsp_data == 0
- busy  out  1  state != IDLE

## Operation
- Three-state FSM: IDLE, EXEC, RESP.
- IDLE: if any valid, pick a winner, pulse the winner's ready for one cycle (combinational, only in IDLE), latch data/amt/dir/id, go to EXEC. No valid: stay.
- Arbitration: one-bit priority pointer `pri` (0 = A preferred). Only one valid: that one wins. Both valid: `pri` side wins. After each grant, `pri` points to the non-granted requester, so back-to-back contention alternates A, B, A, …
- The loser's ready stays 0. The loser must hold valid and its fields stable until accepted. Requesters must not drop valid before ready.
- EXEC: compute the rotation into the result register, go to RESP.
  - Left: result[i] = op[(i − amt) mod N]. Right: result[i] = op[(i + amt) mod N].
  - amt = 0 in either direction returns the operand unchanged. No shift-by-N artifact is permitted.
- RESP: rsp_valid = 1; rsp_data, rsp_id and rsp_zero are held stable. On rsp_valid && rsp_ready, go to IDLE. While rsp_ready = 0, hold indefinitely.
- No new request is accepted outside IDLE.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): state = IDLE, pri = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0, rsp_zero = 1, busy = 0, a_ready = b_ready = 0 until the first clock edge with valid.
- Latency: accept in cycle T, rsp_valid rises at T+2.
- Throughput: one operation per 3 cycles when rsp_ready is held high. A response consumed in cycle T allows a new accept at T+1.
- Reset asserted in EXEC or RESP: the operation is dropped, no response is produced, and outputs take their reset values immediately.
- Simultaneous a_valid rising and a response completing: the request is accepted on the next cycle (IDLE only).
- rsp_zero is registered with rsp_data. It never changes while rsp_valid = 1.

## Test plan
- Single op: A sends data = 0x8001, amt = 1, dir = 1, rsp_ready = 1. a_ready pulses once; 2 cycles later rsp_data = 0x0003, rsp_id = 0, rsp_zero = 0.
- Right wrap and zero amount: B sends 0x0001, amt = 15, right → 0x0002, id = 1. Then B sends 0x1234, amt = 0, left → 0x1234.
- Contention fairness: A and B both valid continuously for 4 ops after reset. Grants are A, B, A, B. The loser's ready stays 0 while the other is in service, and each response's ID matches the grant order.
- Backpressure: hold rsp_ready = 0 for 10 cycles after rsp_valid. rsp_data/rsp_id are stable, busy = 1, and no ready pulses. Release → IDLE the next cycle.
- Reset mid-op: assert rst_n = 0 during EXEC. rsp_valid never rises. After release, a new A op completes normally with pri = 0.
- Zero flag: A sends 0x0000, amt = 7 → rsp_data = 0x0000, rsp_zero = 1.

Source files
------------

// File: rtl/rot_arbiter.sv
// Two-requester round-robin front end for the 16-bit rotate datapath.
// One operation in flight: IDLE accepts, EXEC rotates, RESP holds the tagged result.
module rot_arbiter #(
    parameter  int N  = 16,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [N-1:0]  a_data,
    input  logic [AW-1:0] a_amt,
    input  logic          a_dir,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [N-1:0]  b_data,
    input  logic [AW-1:0] b_amt,
    input  logic          b_dir,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [N-1:0]  rsp_data,
    output logic          rsp_id,
    output logic          rsp_zero,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic          pri;
    logic [N-1:0]  op_q;
    logic [AW-1:0] amt_q;
    logic          dir_q;
    logic          id_q;
    logic [N-1:0]  rot_res;

    // Doubling the operand turns the rotate into a plain shift with no shift-by-N case.
    function automatic logic [N-1:0] rotate(input logic [N-1:0]  op,
                                            input logic [AW-1:0] amt,
                                            input logic          left);
        logic [2*N-1:0] dbl;
        begin
            if (left) begin
                dbl    = {op, op} << amt;
                rotate = dbl[2*N-1:N];
            end else begin
                dbl    = {op, op} >> amt;
                rotate = dbl[N-1:0];
            end
        end
    endfunction

    assign a_ready   = (state == IDLE) && a_valid && (!b_valid || !pri);
    assign b_ready   = (state == IDLE) && b_valid && (!a_valid || pri);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign rot_res   = rotate(op_q, amt_q, dir_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pri      <= 1'b0;
            op_q     <= '0;
            amt_q    <= '0;
            dir_q    <= 1'b0;
            id_q     <= 1'b0;
            rsp_data <= '0;
            rsp_id   <= 1'b0;
            rsp_zero <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (a_ready || b_ready) begin
                        op_q  <= b_ready ? b_data : a_data;
                        amt_q <= b_ready ? b_amt  : a_amt;
                        dir_q <= b_ready ? b_dir  : a_dir;
                        id_q  <= b_ready;
                        // Pointer moves to whichever side just lost (or did not ask).
                        pri   <= a_ready;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data <= rot_res;
                    rsp_zero <= (rot_res == '0);
                    rsp_id   <= id_q;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
